// File: rtl/pattern_detector_mealy.sv
// ---------------------------------------------------------------------------
// pattern_detector_mealy
//   Mealy serial pattern recogniser for one 1-bit stream. The pattern
//   (1..MAX_LEN bits) is programmable at runtime. With the default
//   parameters the block detects "1101" straight out of reset.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   a            serial data bit
//   en           a is valid this cycle
//   overlap      1 = overlapping matches allowed, 0 = non-overlapping
//   cfg_load     load cfg_pattern/cfg_len this cycle (wins over en)
//   cfg_pattern  pattern; bit [L-1] is received first, bit [0] last
//   cfg_len      pattern length L (values above MAX_LEN are clamped)
//   clr_count    synchronous clear of match_count
//   match        combinational Mealy output from a/en/state
//   match_q      match delayed by one clock
//   match_count  saturating count of matches
//   cur_len      active pattern length
// ---------------------------------------------------------------------------
module pattern_detector_mealy #(
  parameter int                   MAX_LEN     = 8,
  parameter int                   LEN_W       = $clog2(MAX_LEN + 1),
  parameter int                   COUNT_W     = 16,
  parameter logic [MAX_LEN-1:0]   RST_PATTERN = 'b1101,
  parameter int                   RST_LEN     = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               a,
  input  logic               en,
  input  logic               overlap,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               clr_count,
  output logic               match,
  output logic               match_q,
  output logic [COUNT_W-1:0] match_count,
  output logic [LEN_W-1:0]   cur_len
);

  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] FILL_MAX  = LEN_W'(MAX_LEN - 1);
  localparam logic [LEN_W-1:0] LEN_RESET = LEN_W'(RST_LEN);

  // Configuration and stream history.
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic [MAX_LEN-2:0] hist;   // hist[0] is the most recently accepted bit
  logic [LEN_W-1:0]   fill;   // accepted bits counted toward the window

  logic               accept;
  logic [MAX_LEN-1:0] win;
  logic [MAX_LEN-1:0] mask;
  logic               fill_ok;
  logic               pat_eq;

  assign accept = en & ~cfg_load;
  assign win    = {hist, a};

  // Mask selects win[len-1:0]; len = 0 gives an empty mask.
  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
  end

  // fill >= len-1, written as fill+1 >= len to avoid underflow at len = 0.
  assign fill_ok = ({1'b0, fill} + 1'b1) >= {1'b0, len};
  assign pat_eq  = ((win ^ pat) & mask) == '0;
  assign match   = accept & (len != '0) & fill_ok & pat_eq;

  assign cur_len = len;

  // Stream history and configuration.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat  <= RST_PATTERN;
      len  <= LEN_RESET;
      hist <= '0;
      fill <= '0;
    end else if (cfg_load) begin
      pat  <= cfg_pattern;
      len  <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      hist <= '0;
      fill <= '0;
    end else if (en) begin
      hist <= win[MAX_LEN-2:0];
      // A non-overlapping match consumes its bits: the next match needs
      // len fresh bits. hist still shifts so the window stays aligned.
      if (match && !overlap) begin
        fill <= '0;
      end else if (fill < FILL_MAX) begin
        fill <= fill + 1'b1;
      end
    end
  end

  // Registered copy of match and the saturating counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_q     <= 1'b0;
      match_count <= '0;
    end else begin
      match_q <= match;
      if (cfg_load || clr_count) begin
        match_count <= '0;                 // clear wins over a coincident match
      end else if (match && !(&match_count)) begin
        match_count <= match_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_detector_mealy.sv
// ---------------------------------------------------------------------------
// tb_pattern_detector_mealy
//   Self-checking bench for pattern_detector_mealy (MAX_LEN=8, COUNT_W=4).
//   The stimulus process drives one cycle at a time and pushes the expected
//   outputs for that cycle into a queue; the monitor samples the DUT on the
//   falling edge and compares against the popped entry. The reference model
//   keeps the list of bits accepted since the last window clear and checks
//   the pattern bit by bit.
// ---------------------------------------------------------------------------
module tb_pattern_detector_mealy;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int COUNT_W = 4;
  localparam int CNT_MAX = (1 << COUNT_W) - 1;

  logic               clk;
  logic               reset_n;
  logic               a;
  logic               en;
  logic               overlap;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               clr_count;
  logic               match;
  logic               match_q;
  logic [COUNT_W-1:0] match_count;
  logic [LEN_W-1:0]   cur_len;

  pattern_detector_mealy #(
    .MAX_LEN (MAX_LEN),
    .COUNT_W (COUNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .a           (a),
    .en          (en),
    .overlap     (overlap),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .clr_count   (clr_count),
    .match       (match),
    .match_q     (match_q),
    .match_count (match_count),
    .cur_len     (cur_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic       m;
    logic       mq;
    logic [3:0] cnt;
    logic [3:0] len;
  } exp_t;

  exp_t exp_q[$];

  // Monitor: one expected entry per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("match",       32'(match),       32'(e.m));
      check("match_q",     32'(match_q),     32'(e.mq));
      check("match_count", 32'(match_count), 32'(e.cnt));
      check("cur_len",     32'(cur_len),     32'(e.len));
    end
  end

  // ---------------------------------------------------------- reference model
  bit       acc_bits[$];   // bits accepted since the window was last cleared
  bit [7:0] m_pat;
  int       m_len;
  int       m_cnt;
  bit       m_prev;

  task automatic model_reset();
    acc_bits.delete();
    m_pat  = 8'b0000_1101;
    m_len  = 4;
    m_cnt  = 0;
    m_prev = 1'b0;
  endtask

  // Drive one cycle, push its expected outputs, advance the model.
  task automatic step(input bit ai, input bit ei, input bit ov, input bit ld,
                      input bit [7:0] cp, input int cl, input bit clr);
    bit   exp_m;
    exp_t e;
    a = ai; en = ei; overlap = ov; cfg_load = ld;
    cfg_pattern = cp; cfg_len = 4'(cl); clr_count = clr;

    // Pattern bit 0 is the current bit, bit j the one received j bits ago.
    exp_m = 1'b0;
    if (ei && !ld && m_len >= 1 && acc_bits.size() >= m_len - 1) begin
      exp_m = 1'b1;
      for (int j = 0; j < m_len; j++) begin
        bit w;
        w = (j == 0) ? ai : acc_bits[acc_bits.size() - j];
        if (w != m_pat[j]) exp_m = 1'b0;
      end
    end

    e.m = exp_m; e.mq = m_prev; e.cnt = 4'(m_cnt); e.len = 4'(m_len);
    exp_q.push_back(e);

    if (ld) begin
      m_pat = cp;
      m_len = (cl > MAX_LEN) ? MAX_LEN : cl;
      acc_bits.delete();
    end else if (ei) begin
      if (exp_m && !ov) begin
        acc_bits.delete();
      end else begin
        acc_bits.push_back(ai);
        if (acc_bits.size() > MAX_LEN) void'(acc_bits.pop_front());
      end
    end
    if (ld || clr)                      m_cnt = 0;
    else if (exp_m && m_cnt < CNT_MAX)  m_cnt++;
    m_prev = exp_m;

    @(posedge clk); #1; cyc++;
  endtask

  task automatic bit_in(input bit ai, input bit ov);
    step(ai, 1'b1, ov, 1'b0, 8'h00, 0, 1'b0);
  endtask

  task automatic idle(input bit ai);
    step(ai, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0);
  endtask

  task automatic load(input bit [7:0] cp, input int cl);
    step(1'b0, 1'b0, 1'b0, 1'b1, cp, cl, 1'b0);
  endtask

  // Mid-stream reset held for one cycle.
  task automatic pulse_reset();
    exp_t e;
    a = 1'b0; en = 1'b0; cfg_load = 1'b0; clr_count = 1'b0;
    reset_n = 1'b0;
    model_reset();
    e.m = 1'b0; e.mq = 1'b0; e.cnt = 4'd0; e.len = 4'd4;
    exp_q.push_back(e);
    @(posedge clk); #1; cyc++;
    reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- stimulus
  bit s7[7] = '{1, 1, 0, 1, 1, 0, 1};

  initial begin
    reset_n = 1'b0; a = 1'b0; en = 1'b0; overlap = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; clr_count = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset match",       32'(match),       32'd0);
    check("reset match_q",     32'(match_q),     32'd0);
    check("reset match_count", 32'(match_count), 32'd0);
    check("reset cur_len",     32'(cur_len),     32'd4);
    reset_n = 1'b1;

    // 1101 overlapping: matches on bits 4 and 7, count 2.
    foreach (s7[i]) bit_in(s7[i], 1'b1);
    idle(1'b0);
    // Same stream non-overlapping: match on bit 4 only.
    pulse_reset();
    foreach (s7[i]) bit_in(s7[i], 1'b0);
    idle(1'b0);

    // 111 with five ones: three matches overlapping, one non-overlapping.
    load(8'b111, 3);
    repeat (5) bit_in(1'b1, 1'b1);
    load(8'b111, 3);
    repeat (5) bit_in(1'b1, 1'b0);

    // en gaps inside 1101; match stays low while en=0.
    pulse_reset();
    bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1); idle(1'b1);
    bit_in(1'b0, 1'b1); idle(1'b1); bit_in(1'b1, 1'b1);
    idle(1'b0);

    // Reset after 1,1,0 discards the history.
    pulse_reset();
    bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1);
    pulse_reset();
    bit_in(1'b1, 1'b1);
    idle(1'b0);

    // cfg_load in the cycle of the final matching bit.
    bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'b1101, 4, 1'b0);
    idle(1'b0);

    // len clamp, len = 0 never matches.
    load(8'hFF, 12);
    repeat (9) bit_in(1'b1, 1'b1);
    load(8'h00, 0);
    repeat (4) bit_in(1'b0, 1'b1);

    // Counter saturation with len=1, then clear coincident with a match.
    load(8'b1, 1);
    repeat (17) bit_in(1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b1);
    bit_in(1'b1, 1'b1);
    idle(1'b0);

    // Randomised traffic, short patterns mostly so matches are frequent.
    pulse_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        load(8'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10)
                                                       : $urandom_range(1, 4));
      end else if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else begin
        step(1'($urandom), ($urandom_range(0, 9) < 8), 1'($urandom), 1'b0,
             8'h00, 0, ($urandom_range(0, 49) == 0));
      end
    end

    idle(1'b0);
    @(posedge clk); #1;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog against a stalled run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pattern_detector_mealy.md
Name: pattern_detector_mealy

Overview:
- Parametrised Mealy serial pattern recogniser for one 1-bit stream, with a runtime-programmable pattern of 1..MAX_LEN bits.
- Supports overlapping or non-overlapping detection, a sample-enable qualifier, a registered copy of the match output, and a saturating match counter.
- Successor to the fixed 4-bit "1101" detector. With default parameters it detects 1101 out of reset.
- Sits between a serial bit source and the control or status logic that consumes match pulses.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(MAX_LEN+1), width of cfg_len.
- COUNT_W, 16, width of the match counter.
- RST_PATTERN, 'b1101 (MAX_LEN bits, zero-extended), pattern loaded at reset.
- RST_LEN, 4, pattern length loaded at reset.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- a  in  1  serial data bit
- en  in  1  a is valid this cycle
- overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping
- cfg_load  in  1  load cfg_pattern/cfg_len this cycle
- cfg_pattern  in  MAX_LEN  pattern; bit [L-1] is received first, bit [0] last
- cfg_len  in  LEN_W  pattern length L
- clr_count  in  1  synchronous clear of match_count
- match  out  1  Mealy output, combinational in a/en/state
- match_q  out  1  match registered (1-cycle delay)
- match_count  out  COUNT_W  saturating count of matches
- cur_len  out  LEN_W  active pattern length

Behaviour:
- Reset: one clock, asynchronous active-low. Asserting reset_n=0 mid-stream discards all history immediately.
  - pat = RST_PATTERN, len = RST_LEN, hist = 0, fill = 0.
  - match_count = 0, match_q = 0. match = 0 because fill = 0.
- State:
  - hist[MAX_LEN-2:0]: previously accepted bits; hist[0] is the most recent.
  - fill: number of accepted bits counted toward the current window, saturating at MAX_LEN-1.
  - pat, len: active configuration.
- Window: win = {hist, a}, MAX_LEN bits, with win[0] = a.
- Match condition, all of the following in the same cycle:
  - en = 1 and cfg_load = 0;
  - 1 <= len;
  - fill >= len-1;
  - win[len-1:0] == pat[len-1:0].
- When match = 1, no register update is needed for the output itself; it is combinational from current state and a.
- Accepted bit (en=1, cfg_load=0) at clock edge:
  - hist <= {hist[MAX_LEN-3:0], a}.
  - If match and overlap=0: fill <= 0, so the next match needs len fresh bits.
  - Otherwise: fill <= min(fill+1, MAX_LEN-1).
- en = 0: hist and fill hold; match = 0.
- cfg_load = 1 (takes priority over en):
  - pat <= cfg_pattern; len <= cfg_len clamped to MAX_LEN; hist <= 0; fill <= 0; match_count <= 0.
  - The sample presented that cycle is discarded and match = 0.
  - The new pattern is active from the next cycle.
- len = 0 (programmed): match is never asserted; bits are still shifted in.
- len = 1: match = en & (a == pat[0]). In non-overlap mode a match resets fill to 0, but len-1 = 0 so every matching bit still matches.
- match_q <= match every cycle.
- match_count:
  - Increments on each match and saturates at all-ones.
  - clr_count clears it. If clr_count and match coincide, the clear wins (result 0).
- overlap may change on any cycle; it is sampled only in the cycle a match occurs.
- cur_len = len.

Test Plan:
- After reset, en=1, a stream 1,1,0,1,1,0,1, overlap=1 -> match on bits 4 and 7 only; match_q one cycle later; match_count = 2.
- Same stream as above with overlap=0 -> match on bit 4 only (bit 7 suppressed because fill = 2 < 3); match_count = 1.
- cfg_load with pattern 'b111, len 3, then 1,1,1,1,1:
  - overlap=1 -> matches on bits 3, 4, 5 (count 3);
  - overlap=0 -> match on bit 3 only (count 1).
- en gaps: 1101 presented as 1,1,(en=0),0,(en=0),1 -> single match on the final bit; match stays 0 during en=0 cycles.
- Reset and config boundaries:
  - Assert reset_n=0 after bits 1,1,0, then release and send 1 -> no match.
  - cfg_load asserted in the same cycle as the final matching bit -> match = 0 and match_count = 0.
- Counter boundaries:
  - Preload near saturation (COUNT_W=4 build): after 15 matches, a further match -> match_count stays 15.
  - clr_count coincident with a match -> match_count = 0.
